// File: rtl/parity_gen.sv
// Registered even/odd parity generator with optional receive-side checker.
// Define PARITY_CHECK_EN to add rx_par/par_odd inputs and par_err/err_cnt outputs.
module parity_gen #(
  parameter int WIDTH  = 9,
  parameter int ERR_CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  x,
`ifdef PARITY_CHECK_EN
  input  logic              rx_par,
  input  logic              par_odd,
  output logic              par_err,
  output logic [ERR_CW-1:0] err_cnt,
`endif
  output logic              out_valid,
  output logic [WIDTH-1:0]  x_q,
  output logic              ep,
  output logic              op
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ep_q, ep_d;
  logic             ep_next;

  assign ep_next = ^x;

  always_comb begin
    out_valid_d = in_valid;
    data_d      = data_q;
    ep_d        = ep_q;
    if (in_valid) begin
      data_d = x;
      ep_d   = ep_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ep_q        <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      ep_q        <= ep_d;
    end
  end

  assign out_valid = out_valid_q;
  assign x_q       = data_q;
  assign ep        = ep_q;
  // Odd parity is the complement in every state, reset included
  assign op        = ~ep_q;

`ifdef PARITY_CHECK_EN
  logic              op_next;
  logic              par_err_q, par_err_d;
  logic [ERR_CW-1:0] err_cnt_q, err_cnt_d;

  assign op_next = ~ep_next;

  always_comb begin
    par_err_d = 1'b0;
    err_cnt_d = err_cnt_q;
    if (in_valid)
      par_err_d = rx_par ^ (par_odd ? op_next : ep_next);
    if (par_err_d && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + ERR_CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      par_err_q <= par_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign par_err = par_err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_gen.sv
// Self-checking bench for parity_gen: directed steps plus random traffic
// checked against a popcount-based reference model.
module tb_parity_gen;
  localparam int WIDTH  = 9;
  localparam int ERR_CW = 8;
  localparam int CMAX   = (1 << ERR_CW) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [WIDTH-1:0] x;
  logic             out_valid;
  logic [WIDTH-1:0] x_q;
  logic             ep;
  logic             op;
`ifdef PARITY_CHECK_EN
  logic              rx_par;
  logic              par_odd;
  logic              par_err;
  logic [ERR_CW-1:0] err_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // reference model state
  logic             m_valid;
  logic [WIDTH-1:0] m_x;
  logic             m_ep;
  logic             m_err;
  int               m_cnt;

  always #5 clk = ~clk;

  parity_gen #(.WIDTH(WIDTH), .ERR_CW(ERR_CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .x        (x),
`ifdef PARITY_CHECK_EN
    .rx_par   (rx_par),
    .par_odd  (par_odd),
    .par_err  (par_err),
    .err_cnt  (err_cnt),
`endif
    .out_valid(out_valid),
    .x_q      (x_q),
    .ep       (ep),
    .op       (op)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
    chk({tag, ".x_q"}, 64'(x_q), 64'(m_x));
    chk({tag, ".ep"}, 64'(ep), 64'(m_ep));
    chk({tag, ".op"}, 64'(op), 64'(!m_ep));
`ifdef PARITY_CHECK_EN
    chk({tag, ".par_err"}, 64'(par_err), 64'(m_err));
    chk({tag, ".err_cnt"}, 64'(err_cnt), 64'(m_cnt));
`endif
  endtask

  // One clock: drive on negedge, model the edge, sample 1 ns after it
  task automatic step(input string tag, input logic r, input logic v,
                      input logic [WIDTH-1:0] d, input logic rp,
                      input logic po);
    int ones;
    logic par;
    @(negedge clk);
    rst      = r;
    in_valid = v;
    x        = d;
`ifdef PARITY_CHECK_EN
    rx_par   = rp;
    par_odd  = po;
`endif
    @(posedge clk);
    ones = $countones(d);
    par  = (ones % 2) == 1;
    if (r) begin
      m_valid = 1'b0; m_x = '0; m_ep = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else if (v) begin
      m_valid = 1'b1; m_x = d; m_ep = par;
      m_err = rp != (po ? !par : par);
      if (m_err && m_cnt < CMAX) m_cnt++;
    end else begin
      m_valid = 1'b0; m_err = 1'b0;
    end
`ifndef PARITY_CHECK_EN
    m_err = 1'b0; m_cnt = 0;
`endif
    #1;
    check_all(tag);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; x = '0;
`ifdef PARITY_CHECK_EN
    rx_par = 1'b0; par_odd = 1'b0;
`endif
    m_valid = 1'b0; m_x = '0; m_ep = 1'b0; m_err = 1'b0; m_cnt = 0;

    step("rst0", 1, 0, '0, 0, 0);
    step("rst1", 1, 0, '0, 0, 0);
    step("idle", 0, 0, '0, 0, 0);
    step("zero", 0, 1, 9'h000, 0, 0);
    step("ones", 0, 1, 9'h1FF, 1, 0);
    step("alt",  0, 1, 9'h155, 1, 0);
    step("two",  0, 1, 9'h003, 0, 0);
    step("b2b0", 0, 1, 9'h001, 0, 1);
    step("b2b1", 0, 1, 9'h0F0, 1, 1);
    step("b2b2", 0, 1, 9'h100, 0, 1);
    step("hold0", 0, 0, 9'h0AA, 1, 0);
    step("hold1", 0, 0, 9'h123, 0, 1);
    step("rstmid", 1, 1, 9'h1FF, 0, 0);
    step("err1", 0, 1, 9'h1FF, 0, 0);
    step("err0", 0, 1, 9'h1FF, 1, 0);
    step("odd1", 0, 1, 9'h1FF, 1, 1);

    for (int i = 0; i < 600; i++) begin
      step("rand", 0, 1'($urandom_range(0, 3) != 0),
           WIDTH'($urandom), 1'($urandom), 1'($urandom));
    end
    // force sustained mismatches to drive the counter into saturation
    for (int i = 0; i < 300; i++) begin
      logic [WIDTH-1:0] d;
      d = WIDTH'($urandom);
      step("sat", 0, 1, d, 1'(~^d), 0);
    end
    step("rstend", 1, 0, '0, 0, 0);
    step("idleend", 0, 0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
